// File: rtl/stim_seq_pkg.sv
// Shared types for the stimulus sequencer: FSM state encoding, step-table
// entry layout and a small helper that maps a zero hold onto one cycle.
package stim_seq_pkg;

  localparam int ADDR_W_DEF = 6;
  localparam int HOLD_W_DEF = 8;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  typedef struct packed {
    logic [ADDR_W_DEF-1:0] addr;
    logic                  wr;
    logic                  en;
    logic [HOLD_W_DEF-1:0] hold;
  } step_t;

  // A stored hold of zero still shows the step for one cycle.
  function automatic logic [HOLD_W_DEF-1:0] eff_hold(input logic [HOLD_W_DEF-1:0] h);
    return (h == '0) ? HOLD_W_DEF'(1) : h;
  endfunction

endpackage

// File: rtl/stim_seq_gen_table.sv
// Step table: DEPTH entries of step_t with one synchronous write port and
// one combinational read port. Contents are deliberately not reset; the
// user programs every entry that a playback will touch.
module stim_step_table
  import stim_seq_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [IDX_W-1:0] wr_idx,
  input  step_t            wr_data,
  input  logic [IDX_W-1:0] rd_idx,
  output step_t            rd_data
);

  step_t mem [DEPTH];

  // Write the addressed entry on the clock edge when enabled.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_idx] <= wr_data;
    end
  end

  // The read is combinational so a write on the same edge is not yet
  // visible; the reader always sees the pre-write contents.
  always_comb begin
    rd_data = mem[rd_idx];
  end

endmodule

// File: rtl/stim_seq_gen.sv
// Programmable stimulus sequencer. Plays a table of addr/wr/en steps, each
// held for a programmable number of cycles, in one-shot or loop mode.
// All outputs come straight from flops.
module stim_seq_gen
  import stim_seq_pkg::*;
#(
  parameter  int ADDR_W = ADDR_W_DEF,
  parameter  int DEPTH  = 8,
  parameter  int HOLD_W = HOLD_W_DEF,
  localparam int IDX_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_we,
  input  logic [IDX_W-1:0]  cfg_idx,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic              cfg_wr,
  input  logic              cfg_en,
  input  logic [HOLD_W-1:0] cfg_hold,
  input  logic [IDX_W:0]    num_steps,
  input  logic              loop_mode,
  input  logic              start,
  input  logic              stop,
  output logic [ADDR_W-1:0] addr,
  output logic              wr,
  output logic              en,
  output logic              busy,
  output logic              done,
  output logic [IDX_W-1:0]  step_idx
);

  state_t            state_q, state_d;
  logic [HOLD_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [IDX_W-1:0]  last_q, last_d;
  logic              loop_q, loop_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              wr_q, wr_d;
  logic              en_q, en_d;
  logic              done_q, done_d;

  logic              tbl_we;
  step_t             tbl_wr_data;
  logic [IDX_W-1:0]  rd_idx;
  step_t             rd_step;
  logic              at_last;
  logic [IDX_W:0]    ns_eff;
  logic [IDX_W:0]    ns_minus1;
  logic [IDX_W-1:0]  last_from_ns;
  logic [HOLD_W-1:0] load_hold;

  // Table writes are accepted only while idle; writes during playback are
  // dropped so the running pattern cannot change underneath itself.
  always_comb begin
    tbl_we      = cfg_we && (state_q == IDLE);
    tbl_wr_data = '{addr: ADDR_W_DEF'(cfg_addr),
                    wr:   cfg_wr,
                    en:   cfg_en,
                    hold: HOLD_W_DEF'(cfg_hold)};
  end

  stim_step_table #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_table (
    .clk     (clk),
    .we      (tbl_we),
    .wr_idx  (cfg_idx),
    .wr_data (tbl_wr_data),
    .rd_idx  (rd_idx),
    .rd_data (rd_step)
  );

  // Read port points at the step that would be loaded on the next advance:
  // step 0 when idle or wrapping, otherwise the following step.
  always_comb begin
    at_last = (idx_q == last_q);
    if ((state_q == RUN) && !at_last) begin
      rd_idx = idx_q + IDX_W'(1);
    end else begin
      rd_idx = '0;
    end
  end

  // Clamp the requested step count into 1..DEPTH and derive the last index;
  // also compute the cycle count for whichever step is being loaded.
  always_comb begin
    if (num_steps == '0) begin
      ns_eff = (IDX_W+1)'(1);
    end else if (num_steps > (IDX_W+1)'(DEPTH)) begin
      ns_eff = (IDX_W+1)'(DEPTH);
    end else begin
      ns_eff = num_steps;
    end
    ns_minus1    = ns_eff - (IDX_W+1)'(1);
    last_from_ns = ns_minus1[IDX_W-1:0];
    load_hold    = HOLD_W'(eff_hold(rd_step.hold));
  end

  // Next-state logic: start loads step 0, the hold counter paces each step,
  // and the last step either wraps (loop) or finishes with a done pulse.
  // stop is checked before completion so it suppresses done.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    last_d  = last_q;
    loop_d  = loop_q;
    addr_d  = addr_q;
    wr_d    = wr_q;
    en_d    = en_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          last_d  = last_from_ns;
          loop_d  = loop_mode;
          idx_d   = '0;
          addr_d  = ADDR_W'(rd_step.addr);
          wr_d    = rd_step.wr;
          en_d    = rd_step.en;
          cnt_d   = load_hold;
        end
      end
      RUN: begin
        if (stop) begin
          state_d = IDLE;
          wr_d    = 1'b0;
          en_d    = 1'b0;
          cnt_d   = '0;
        end else if (cnt_q <= HOLD_W'(1)) begin
          if (at_last && !loop_q) begin
            state_d = IDLE;
            wr_d    = 1'b0;
            en_d    = 1'b0;
            done_d  = 1'b1;
            cnt_d   = '0;
          end else begin
            idx_d  = rd_idx;
            addr_d = ADDR_W'(rd_step.addr);
            wr_d   = rd_step.wr;
            en_d   = rd_step.en;
            cnt_d  = load_hold;
          end
        end else begin
          cnt_d = cnt_q - HOLD_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      last_q  <= '0;
      loop_q  <= 1'b0;
      addr_q  <= '0;
      wr_q    <= 1'b0;
      en_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      loop_q  <= loop_d;
      addr_q  <= addr_d;
      wr_q    <= wr_d;
      en_q    <= en_d;
      done_q  <= done_d;
    end
  end

  assign addr     = addr_q;
  assign wr       = wr_q;
  assign en       = en_q;
  assign busy     = (state_q == RUN);
  assign done     = done_q;
  assign step_idx = idx_q;

endmodule

// File: tb/tb_stim_seq_gen.sv
// Self-checking bench for stim_seq_gen. Expected per-cycle outputs are
// expanded from a shadow copy of the programmed table into a queue when a
// playback is launched, then popped and compared cycle by cycle.
module tb_stim_seq_gen;

  localparam int ADDR_W = 6;
  localparam int DEPTH  = 8;
  localparam int HOLD_W = 8;
  localparam int IDX_W  = 3;

  logic              clk;
  logic              rst_n;
  logic              cfg_we;
  logic [IDX_W-1:0]  cfg_idx;
  logic [ADDR_W-1:0] cfg_addr;
  logic              cfg_wr;
  logic              cfg_en;
  logic [HOLD_W-1:0] cfg_hold;
  logic [IDX_W:0]    num_steps;
  logic              loop_mode;
  logic              start;
  logic              stop;
  logic [ADDR_W-1:0] addr;
  logic              wr;
  logic              en;
  logic              busy;
  logic              done;
  logic [IDX_W-1:0]  step_idx;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              wr;
    logic              en;
    logic              busy;
    logic              done;
    logic [IDX_W-1:0]  idx;
    logic              chk_idx;
  } exp_t;

  exp_t expQ[$];
  int   checkCount = 0;
  int   errorCount = 0;

  logic [ADDR_W-1:0] shAddr [DEPTH];
  logic              shWr   [DEPTH];
  logic              shEn   [DEPTH];
  logic [HOLD_W-1:0] shHold [DEPTH];

  stim_seq_gen dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_we    (cfg_we),
    .cfg_idx   (cfg_idx),
    .cfg_addr  (cfg_addr),
    .cfg_wr    (cfg_wr),
    .cfg_en    (cfg_en),
    .cfg_hold  (cfg_hold),
    .num_steps (num_steps),
    .loop_mode (loop_mode),
    .start     (start),
    .stop      (stop),
    .addr      (addr),
    .wr        (wr),
    .en        (en),
    .busy      (busy),
    .done      (done),
    .step_idx  (step_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard time limit so the bench can never hang.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired checks=%0d", checkCount);
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic programStep(input int i, input logic [ADDR_W-1:0] a, input logic w,
                             input logic e, input logic [HOLD_W-1:0] h);
    cfg_idx  = i[IDX_W-1:0];
    cfg_addr = a;
    cfg_wr   = w;
    cfg_en   = e;
    cfg_hold = h;
    cfg_we   = 1'b1;
    tick();
    cfg_we   = 1'b0;
    shAddr[i] = a;
    shWr[i]   = w;
    shEn[i]   = e;
    shHold[i] = h;
  endtask

  task automatic pushCycle(input logic [ADDR_W-1:0] a, input logic w, input logic e,
                           input logic b, input logic d, input int s, input logic ci);
    exp_t x;
    x.addr    = a;
    x.wr      = w;
    x.en      = e;
    x.busy    = b;
    x.done    = d;
    x.idx     = s[IDX_W-1:0];
    x.chk_idx = ci;
    expQ.push_back(x);
  endtask

  // One-shot playback: each step repeated max(hold,1) times, then the done
  // cycle and one quiet idle cycle after it.
  task automatic pushOneShot(input int ns);
    int eff;
    int h;
    eff = (ns == 0) ? 1 : ((ns > DEPTH) ? DEPTH : ns);
    for (int s = 0; s < eff; s++) begin
      h = (shHold[s] == 0) ? 1 : int'(shHold[s]);
      for (int k = 0; k < h; k++) pushCycle(shAddr[s], shWr[s], shEn[s], 1'b1, 1'b0, s, 1'b1);
    end
    pushCycle(shAddr[eff-1], 1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b0);
    pushCycle(shAddr[eff-1], 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
  endtask

  // Busy cycles of a playback cycling through ns steps, cut after n cycles.
  task automatic pushRunning(input int ns, input int n);
    int s;
    int k;
    int h;
    s = 0;
    k = 0;
    for (int c = 0; c < n; c++) begin
      pushCycle(shAddr[s], shWr[s], shEn[s], 1'b1, 1'b0, s, 1'b1);
      h = (shHold[s] == 0) ? 1 : int'(shHold[s]);
      k++;
      if (k == h) begin
        k = 0;
        s = (s + 1) % ns;
      end
    end
  endtask

  task automatic compareFront(input string tag);
    exp_t x;
    x = expQ.pop_front();
    checkOutput({tag, ".addr"}, 32'(addr), 32'(x.addr));
    checkOutput({tag, ".wr"},   32'(wr),   32'(x.wr));
    checkOutput({tag, ".en"},   32'(en),   32'(x.en));
    checkOutput({tag, ".busy"}, 32'(busy), 32'(x.busy));
    checkOutput({tag, ".done"}, 32'(done), 32'(x.done));
    if (x.chk_idx) checkOutput({tag, ".idx"}, 32'(step_idx), 32'(x.idx));
  endtask

  // Compare n queued cycles; at cycle weAt also attempt a table write to
  // entry 1, which the DUT must drop because it is busy.
  task automatic drainN(input string tag, input int n, input int weAt);
    for (int k = 0; k < n; k++) begin
      compareFront(tag);
      if (k == weAt) begin
        cfg_idx  = 3'd1;
        cfg_addr = 6'd63;
        cfg_wr   = 1'b0;
        cfg_en   = 1'b0;
        cfg_hold = 8'd7;
        cfg_we   = 1'b1;
      end
      if (k < n - 1) begin
        tick();
        cfg_we = 1'b0;
      end
    end
    cfg_we = 1'b0;
  endtask

  task automatic applyStimulus(input int ns, input logic lp);
    num_steps = ns[IDX_W:0];
    loop_mode = lp;
    start     = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  task automatic checkIdleZero(input string tag);
    checkOutput({tag, ".addr"}, 32'(addr),     32'd0);
    checkOutput({tag, ".wr"},   32'(wr),       32'd0);
    checkOutput({tag, ".en"},   32'(en),       32'd0);
    checkOutput({tag, ".busy"}, 32'(busy),     32'd0);
    checkOutput({tag, ".done"}, 32'(done),     32'd0);
    checkOutput({tag, ".idx"},  32'(step_idx), 32'd0);
  endtask

  task automatic programWave();
    programStep(0, 6'd12, 1'b1, 1'b1, 8'd4);
    programStep(1, 6'd14, 1'b1, 1'b1, 8'd4);
    programStep(2, 6'd23, 1'b0, 1'b1, 8'd4);
    programStep(3, 6'd48, 1'b0, 1'b1, 8'd4);
    programStep(4, 6'd56, 1'b0, 1'b0, 8'd4);
  endtask

  initial begin
    rst_n = 1'b0;
    cfg_we = 1'b0; cfg_idx = '0; cfg_addr = '0; cfg_wr = 1'b0; cfg_en = 1'b0; cfg_hold = '0;
    num_steps = '0; loop_mode = 1'b0; start = 1'b0; stop = 1'b0;
    #3;
    checkIdleZero("reset");
    #19;
    rst_n = 1'b1;
    tick();

    // Waveform replay: 5 steps of 4 cycles, done on cycle 21.
    programWave();
    pushOneShot(5);
    applyStimulus(5, 1'b0);
    drainN("wave", expQ.size(), -1);

    // Loop mode: 5,9,9,5,9,9,5 then stop without done.
    programStep(0, 6'd5, 1'b1, 1'b1, 8'd1);
    programStep(1, 6'd9, 1'b0, 1'b1, 8'd2);
    pushRunning(2, 7);
    applyStimulus(2, 1'b1);
    drainN("loop", expQ.size(), -1);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    pushCycle(6'd5, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    compareFront("loopStop");
    tick();
    checkOutput("loopStop.doneLater", 32'(done), 32'd0);

    // stop on the final step's last cycle beats completion.
    programStep(0, 6'd20, 1'b1, 1'b1, 8'd2);
    programStep(1, 6'd21, 1'b1, 1'b1, 8'd2);
    pushRunning(2, 4);
    applyStimulus(2, 1'b0);
    drainN("stopLast", expQ.size(), -1);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    pushCycle(6'd21, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    compareFront("stopLastEdge");
    tick();
    checkOutput("stopLast.doneLater", 32'(done), 32'd0);

    // Hold zero everywhere; num_steps 0 -> one step, DEPTH+3 -> DEPTH steps.
    for (int i = 0; i < DEPTH; i++) programStep(i, 6'(30 + i), i[0], 1'b1, 8'd0);
    pushOneShot(0);
    applyStimulus(0, 1'b0);
    drainN("ns0", expQ.size(), -1);
    pushOneShot(DEPTH + 3);
    applyStimulus(DEPTH + 3, 1'b0);
    drainN("clamp", expQ.size(), -1);

    // Config while busy: write to entry 1 mid-run is dropped.
    programStep(1, 6'd31, 1'b1, 1'b1, 8'd3);
    pushOneShot(3);
    applyStimulus(3, 1'b0);
    drainN("busyWr", expQ.size(), 1);
    pushOneShot(3);
    applyStimulus(3, 1'b0);
    drainN("busyWrReplay", expQ.size(), -1);

    // cfg_we on the accepted start edge: step 0 comes from the old contents.
    pushOneShot(1);
    cfg_idx = 3'd0; cfg_addr = 6'd40; cfg_wr = 1'b1; cfg_en = 1'b0; cfg_hold = 8'd2;
    cfg_we = 1'b1;
    num_steps = 4'd1;
    loop_mode = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    cfg_we = 1'b0;
    drainN("startWr", expQ.size(), -1);
    shAddr[0] = 6'd40; shWr[0] = 1'b1; shEn[0] = 1'b0; shHold[0] = 8'd2;
    pushOneShot(1);
    applyStimulus(1, 1'b0);
    drainN("startWrNew", expQ.size(), -1);

    // Async reset mid-run at step 2, then a full replay from step 0.
    programWave();
    pushOneShot(5);
    applyStimulus(5, 1'b0);
    drainN("preRst", 9, -1);
    #2;
    rst_n = 1'b0;
    #1;
    checkIdleZero("asyncRst");
    expQ.delete();
    @(negedge clk);
    rst_n = 1'b1;
    pushOneShot(5);
    applyStimulus(5, 1'b0);
    drainN("postRst", expQ.size(), -1);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/stim_seq_gen.md
Name: stim_seq_gen

Overview:
- Synthesizable, programmable stimulus sequencer that replaces hand-written testbench tasks which drive en/wr/addr patterns on clock edges.
- A small step table holds, per step, addr/wr/en values and a hold length in cycles. The block plays the table out on clk in one-shot or loop mode.
- Used as a bus-pattern source for memory and peripheral benches, and as an on-chip traffic generator.

Parameters:
- ADDR_W, 6, width of addr and cfg_addr.
- DEPTH, 8, number of step-table entries (power of 2, >=2).
- HOLD_W, 8, width of per-step hold count.
- IDX_W, $clog2(DEPTH), derived; step index width.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- cfg_we  in  1  table write strobe; ignored while busy=1.
- cfg_idx  in  IDX_W  table entry to write.
- cfg_addr  in  ADDR_W  step addr value.
- cfg_wr  in  1  step wr value.
- cfg_en  in  1  step en value.
- cfg_hold  in  HOLD_W  step duration in cycles; 0 is treated as 1.
- num_steps  in  IDX_W+1  steps to play, 1..DEPTH; sampled at start. 0 is treated as 1; values >DEPTH are clamped to DEPTH.
- loop_mode  in  1  1 = restart at step 0 after last step; sampled at start.
- start  in  1  begin playback (honoured only in IDLE).
- stop  in  1  abort playback (honoured only in RUN).
- addr  out  ADDR_W  stimulus address.
- wr  out  1  stimulus write enable.
- en  out  1  stimulus enable.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse on one-shot completion.
- step_idx  out  IDX_W  index of the step currently driven.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - addr=0, wr=0, en=0, busy=0, done=0, step_idx=0; state=IDLE; hold counter=0.
  - Table contents are not reset. Benches must program every used entry.
- States: IDLE, RUN.
- IDLE + start:
  - At that posedge: latch num_steps and loop_mode; load step 0 onto addr/wr/en; step_idx=0; load counter = max(hold0,1); busy=1; go to RUN.
  - Latency from start to first stimulus: 1 edge.
- RUN:
  - Counter decrements each edge. When counter==1 at an edge, advance to the next step on that edge.
  - Each step is therefore visible for exactly max(hold,1) cycles. No gap cycles between steps.
- End of last step (step_idx == num_steps-1, counter==1):
  - loop_mode=1: reload step 0 at that edge and stay in RUN.
  - loop_mode=0: en=0, wr=0, addr keeps the last step's value; busy=0; done=1 for one cycle; go to IDLE.
- stop in RUN:
  - At that edge: en=0, wr=0, addr held; busy=0; no done pulse; go to IDLE.
- Simultaneous events:
  - stop and last-step end on the same edge: stop wins, no done.
  - start and stop in IDLE: start wins, since stop is ignored in IDLE.
  - start in RUN: ignored.
  - cfg_we on the same edge that start is accepted: the write is performed, and step 0 loads from the pre-write table contents.
- Writes: cfg_we in IDLE writes the entry at that edge. cfg_we while busy is dropped silently.
- done is registered and deasserts on the following edge unless a new completion occurs. Back-to-back completions are impossible because start needs IDLE.
- All outputs are registered. No combinational input-to-output path.
- rst_n asserted mid-RUN: immediate return to reset values; the next start begins at step 0.

Decomposition:
- Package stim_seq_pkg:
  - typedef enum {IDLE, RUN} state_t.
  - struct step_t {addr, wr, en, hold}, parametrised through package localparams ADDR_W_DEF and HOLD_W_DEF.
- Sub-module stim_step_table: DEPTH x step_t register file with one synchronous write port and one combinational read port indexed by next-step index.
- Top holds the FSM, hold counter and output registers.

Test Plan:
- Waveform replay: program (12,wr1,en1,h4),(14,1,1,4),(23,0,1,4),(48,0,1,4),(56,0,0,4); num_steps=5, loop_mode=0; pulse start.
  - addr=12 for cycles 1-4, 14 for 5-8, 23 for 9-12, 48 for 13-16, 56 with en=0 for 17-20.
  - Cycle 21: en=0, wr=0, addr=56, done=1, busy=0.
- Loop mode: 2 steps (5,h1),(9,h2), loop_mode=1 -> addr sequence 5,9,9,5,9,9,...; done never asserts; stop -> en=0 next cycle, busy=0, no done.
- Hold zero and clamp: hold=0 on every step with num_steps=0 -> one step, one cycle, then done. Same table with num_steps=DEPTH+3 -> exactly DEPTH single-cycle steps played.
- Stop vs completion: assert stop on the final step's last cycle -> done stays 0, IDLE reached.
- Config while busy: cfg_we to idx 1 during RUN -> entry unchanged; verify on the next playback.
- Async reset mid-RUN: drop rst_n between edges at step 2 -> outputs 0 immediately without waiting for clk; next start replays from step 0 with the table intact.
